// File: rtl/ysyx_23060171_wbarb.sv
// Writeback-port scheduler: two one-entry slots (EXU-direct A, LSU load B) share the GPR write port, oldest tag first.
// Optional perf counters (perf_conflict, perf_retire) under YSYX_23060171_WBARB_PERF_EN.
module ysyx_23060171_wbarb #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [4:0]       a_rw,
  input  logic [31:0]      a_wd,
  input  logic             a_we,
  input  logic [TAG_W-1:0] a_tag,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [4:0]       b_rw,
  input  logic [31:0]      b_wd,
  input  logic             b_we,
  input  logic [TAG_W-1:0] b_tag,
  output logic             wb_valid,
  output logic             wb_we,
  output logic [4:0]       wb_rw,
  output logic [31:0]      wb_wd,
  output logic [TAG_W-1:0] wb_tag
`ifdef YSYX_23060171_WBARB_PERF_EN
  ,
  output logic [31:0]      perf_conflict,
  output logic [31:0]      perf_retire
`endif
);

  localparam int unsigned RW_W = 5;
  localparam int unsigned WD_W = 32;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

  slot_t            a_st, b_st;
  logic [RW_W-1:0]  a_rw_q, b_rw_q;
  logic [WD_W-1:0]  a_wd_q, b_wd_q;
  logic             a_we_q, b_we_q;
  logic [TAG_W-1:0] a_tag_q, b_tag_q;

  logic             gnt_a, gnt_b, both_full;
  logic [TAG_W-1:0] tag_diff;
  logic [RW_W-1:0]  win_rw;
  logic [WD_W-1:0]  win_wd;
  logic             win_we;
  logic [TAG_W-1:0] win_tag;

  // Grant: a lone full slot wins; with both full the older tag (negative modular difference) wins.
  always_comb begin
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    both_full = (a_st == FULL) && (b_st == FULL);
    tag_diff  = TAG_W'(a_tag_q - b_tag_q);
    if (both_full) begin
      if (tag_diff[TAG_W-1] || (tag_diff == '0)) gnt_a = 1'b1;
      else                                      gnt_b = 1'b1;
    end else if (a_st == FULL) begin
      gnt_a = 1'b1;
    end else if (b_st == FULL) begin
      gnt_b = 1'b1;
    end
    a_ready = !flush && ((a_st == EMPTY) || gnt_a);
    b_ready = !flush && ((b_st == EMPTY) || gnt_b);
    win_rw  = gnt_a ? a_rw_q  : b_rw_q;
    win_wd  = gnt_a ? a_wd_q  : b_wd_q;
    win_we  = gnt_a ? a_we_q  : b_we_q;
    win_tag = gnt_a ? a_tag_q : b_tag_q;
  end

  // Slot A: accept reloads even when granted in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_st    <= EMPTY;
      a_rw_q  <= '0;
      a_wd_q  <= '0;
      a_we_q  <= 1'b0;
      a_tag_q <= '0;
    end else if (flush) begin
      a_st <= EMPTY;
    end else if (a_valid && a_ready) begin
      a_st    <= FULL;
      a_rw_q  <= a_rw;
      a_wd_q  <= a_wd;
      a_we_q  <= a_we;
      a_tag_q <= a_tag;
    end else if (gnt_a) begin
      a_st <= EMPTY;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      b_st    <= EMPTY;
      b_rw_q  <= '0;
      b_wd_q  <= '0;
      b_we_q  <= 1'b0;
      b_tag_q <= '0;
    end else if (flush) begin
      b_st <= EMPTY;
    end else if (b_valid && b_ready) begin
      b_st    <= FULL;
      b_rw_q  <= b_rw;
      b_wd_q  <= b_wd;
      b_we_q  <= b_we;
      b_tag_q <= b_tag;
    end else if (gnt_b) begin
      b_st <= EMPTY;
    end
  end

  // Retire register; x0 writes retire without enabling the GPR write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rw    <= '0;
      wb_wd    <= '0;
      wb_tag   <= '0;
    end else if (!flush && (gnt_a || gnt_b)) begin
      wb_valid <= 1'b1;
      wb_we    <= win_we && (win_rw != '0);
      wb_rw    <= win_rw;
      wb_wd    <= win_wd;
      wb_tag   <= win_tag;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
    end
  end

`ifdef YSYX_23060171_WBARB_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_conflict <= '0;
      perf_retire   <= '0;
    end else begin
      if (both_full) perf_conflict <= perf_conflict + 32'd1;
      if (!flush && (gnt_a || gnt_b)) perf_retire <= perf_retire + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Two in-flight entries must never share a sequence tag.
  tag_unique: assert property (@(posedge clock) disable iff (reset)
    !(both_full && (a_tag_q == b_tag_q)))
    else $error("wbarb: equal tags in both slots");
`endif

endmodule

// File: tb/tb_ysyx_23060171_wbarb.sv
// Directed bench for ysyx_23060171_wbarb: latency, age ordering, tag wrap, x0, flush, streaming, async reset.
module tb_ysyx_23060171_wbarb;

  localparam int unsigned TAG_W = 4;

  logic             clock = 1'b0;
  logic             reset, flush;
  logic             a_valid, a_ready, a_we, b_valid, b_ready, b_we;
  logic [4:0]       a_rw, b_rw;
  logic [31:0]      a_wd, b_wd;
  logic [TAG_W-1:0] a_tag, b_tag;
  logic             wb_valid, wb_we;
  logic [4:0]       wb_rw;
  logic [31:0]      wb_wd;
  logic [TAG_W-1:0] wb_tag;
`ifdef YSYX_23060171_WBARB_PERF_EN
  logic [31:0]      perf_conflict, perf_retire;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rf [32];

  ysyx_23060171_wbarb #(.TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .a_valid(a_valid), .a_ready(a_ready), .a_rw(a_rw), .a_wd(a_wd), .a_we(a_we), .a_tag(a_tag),
    .b_valid(b_valid), .b_ready(b_ready), .b_rw(b_rw), .b_wd(b_wd), .b_we(b_we), .b_tag(b_tag),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rw(wb_rw), .wb_wd(wb_wd), .wb_tag(wb_tag)
`ifdef YSYX_23060171_WBARB_PERF_EN
    , .perf_conflict(perf_conflict), .perf_retire(perf_retire)
`endif
  );

  always #5 clock = ~clock;

  // Reference register file fed by the write port.
  always @(posedge clock) if (wb_we) rf[wb_rw] <= wb_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [4:0] rw, input logic [31:0] wd,
                         input logic we, input logic [TAG_W-1:0] tg);
    a_valid = v; a_rw = rw; a_wd = wd; a_we = we; a_tag = tg;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] rw, input logic [31:0] wd,
                         input logic we, input logic [TAG_W-1:0] tg);
    b_valid = v; b_rw = rw; b_wd = wd; b_we = we; b_tag = tg;
  endtask

  initial begin
    int ai, bi, nret, first, last;
    logic af, bf;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    reset = 1'b1; flush = 1'b0;
    drive_a(1'b0, 5'd0, 32'h0, 1'b0, 4'h0);
    drive_b(1'b0, 5'd0, 32'h0, 1'b0, 4'h0);
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_valid", 32'(wb_valid), 32'd0);
    check("rst_we",    32'(wb_we),    32'd0);
    check("rst_rw",    32'(wb_rw),    32'd0);
    check("rst_a_rdy", 32'(a_ready),  32'd1);
    check("rst_b_rdy", 32'(b_ready),  32'd1);

    // Only A: two-cycle latency
    drive_a(1'b1, 5'd5, 32'h11, 1'b1, 4'd3);
    step();
    drive_a(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    check("a_c1_valid", 32'(wb_valid), 32'd0);
    step();
    check("a_valid", 32'(wb_valid), 32'd1);
    check("a_we",    32'(wb_we),    32'd1);
    check("a_rw",    32'(wb_rw),    32'd5);
    check("a_wd",    wb_wd,         32'h11);
    check("a_tag",   32'(wb_tag),   32'd3);
    step();
    check("a_c3_valid", 32'(wb_valid), 32'd0);

    // Both, same rd: older B first, then A
    drive_a(1'b1, 5'd7, 32'hA, 1'b1, 4'd2);
    drive_b(1'b1, 5'd7, 32'hB, 1'b1, 4'd1);
    step();
    drive_a(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    drive_b(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    step();
    check("ord1_wd",  wb_wd,       32'hB);
    check("ord1_tag", 32'(wb_tag), 32'd1);
    step();
    check("ord2_valid", 32'(wb_valid), 32'd1);
    check("ord2_wd",    wb_wd,         32'hA);
    check("ord2_tag",   32'(wb_tag),   32'd2);
    step();
    check("ord_x7", rf[7], 32'hA);

    // Tag wrap: 0xF is older than 0x0
    drive_a(1'b1, 5'd8, 32'h80, 1'b1, 4'h0);
    drive_b(1'b1, 5'd9, 32'h90, 1'b1, 4'hF);
    step();
    drive_a(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    drive_b(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    step();
    check("wrap1_tag", 32'(wb_tag), 32'hF);
    check("wrap1_rw",  32'(wb_rw),  32'd9);
    step();
    check("wrap2_tag", 32'(wb_tag), 32'h0);
    check("wrap2_rw",  32'(wb_rw),  32'd8);

    // x0 write retires without write enable
    drive_a(1'b1, 5'd0, 32'hFFFF, 1'b1, 4'd4);
    step();
    drive_a(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    step();
    check("x0_valid", 32'(wb_valid), 32'd1);
    check("x0_we",    32'(wb_we),    32'd0);

    // Flush with both slots full drops everything
    drive_a(1'b1, 5'd3, 32'h55, 1'b1, 4'd5);
    drive_b(1'b1, 5'd4, 32'h66, 1'b1, 4'd6);
    step();
    drive_a(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    drive_b(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    flush = 1'b1;
    #1;
    check("fl_a_rdy", 32'(a_ready), 32'd0);
    step();
    flush = 1'b0;
    check("fl_valid", 32'(wb_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_post_valid", 32'(wb_valid), 32'd0);
    end
    check("fl_b_rdy", 32'(b_ready), 32'd1);

    // Streaming: A even tags, B odd tags
    ai = 0; bi = 0; nret = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      drive_a(ai < 8, 5'd10, 32'(100 + 2 * ai), 1'b1, TAG_W'(2 * ai));
      drive_b(bi < 8, 5'd11, 32'(101 + 2 * bi), 1'b1, TAG_W'(2 * bi + 1));
      af = a_valid && a_ready;
      bf = b_valid && b_ready;
      step();
      if (af) ai++;
      if (bf) bi++;
      if (wb_valid) begin
        check("st_tag", 32'(wb_tag), 32'(nret % 16));
        if (first < 0) first = cyc;
        last = cyc;
        nret++;
      end
    end
    drive_a(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    drive_b(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    check("st_count", 32'(nret), 32'd16);
    check("st_span",  32'(last - first), 32'd15);
`ifdef YSYX_23060171_WBARB_PERF_EN
    check("perf_conflict_nz", 32'(perf_conflict != 32'd0), 32'd1);
`endif

    // Async reset with both slots full clears outputs immediately
    drive_a(1'b1, 5'd3, 32'h33, 1'b1, 4'd8);
    drive_b(1'b1, 5'd4, 32'h44, 1'b1, 4'd9);
    step();
    drive_a(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    drive_b(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    step();
    check("mr_pre_wd", wb_wd, 32'h33);
    #2;
    reset = 1'b1;
    #1;
    check("mr_valid", 32'(wb_valid), 32'd0);
    check("mr_we",    32'(wb_we),    32'd0);
    check("mr_rw",    32'(wb_rw),    32'd0);
    check("mr_wd",    wb_wd,         32'd0);
    check("mr_tag",   32'(wb_tag),   32'd0);
    @(negedge clock);
    reset = 1'b0;
    step();
    check("mr_a_rdy", 32'(a_ready),  32'd1);
    check("mr_b_rdy", 32'(b_ready),  32'd1);
    check("mr_post",  32'(wb_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
